// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and state encoding for the router packet transmitter
package router_pkg;
    localparam int MAX_LEN = 63;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = 6;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        DONE
    } state_t;
endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request, payload and router-side signals of the packet transmitter
interface router_pkt_tx_if;
    import router_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0]  pay_len;
    logic [7:0]        pay_data;
    logic              pay_valid;
    logic              pay_ready;
    logic              busy;
    logic [7:0]        data_out;
    logic              pkt_valid;
    logic              tx_done;
    logic              tx_err;
    logic              idle;

    modport master (
        output start, dest_addr, pay_len, pay_data, pay_valid, busy,
        input  pay_ready, data_out, pkt_valid, tx_done, tx_err, idle
    );

    modport slave (
        input  start, dest_addr, pay_len, pay_data, pay_valid, busy,
        output pay_ready, data_out, pkt_valid, tx_done, tx_err, idle
    );
endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - payload buffer, synchronous write and combinational read
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a payload, then sends header, payload and XOR parity to the router
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = router_pkg::MAX_LEN
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_tx_if.slave bus
);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  wr_idx;
    logic [LEN_W-1:0]  rd_idx;
    logic [7:0]        parity;
    logic [7:0]        rd_data;
    logic [7:0]        data_out_r;
    logic              pkt_valid_r;
    logic              pay_ready_r;
    logic              tx_done_r;
    logic              tx_err_r;
    logic              idle_r;
    logic              start_ok;
    logic              wr_en;

    assign start_ok = (bus.dest_addr != INVALID_ADDR) && (bus.pay_len != '0);
    assign wr_en    = (state == LOAD) && bus.pay_valid;

    router_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (LEN_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (bus.pay_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // rd_idx always points at the next byte to present, so data_out can be loaded on each accept
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr_r      <= '0;
            len_r       <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            parity      <= '0;
            data_out_r  <= '0;
            pkt_valid_r <= 1'b0;
            pay_ready_r <= 1'b0;
            tx_done_r   <= 1'b0;
            tx_err_r    <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            tx_done_r <= 1'b0;
            tx_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            state       <= LOAD;
                            addr_r      <= bus.dest_addr;
                            len_r       <= bus.pay_len;
                            wr_idx      <= '0;
                            rd_idx      <= '0;
                            parity      <= '0;
                            pay_ready_r <= 1'b1;
                            idle_r      <= 1'b0;
                        end else begin
                            tx_err_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.pay_valid) begin
                        if (wr_idx == len_r - ONE) begin
                            state       <= HEADER;
                            pay_ready_r <= 1'b0;
                            pkt_valid_r <= 1'b1;
                            data_out_r  <= {len_r, addr_r};
                        end else begin
                            wr_idx <= wr_idx + ONE;
                        end
                    end
                end
                HEADER: begin
                    if (!bus.busy) begin
                        parity     <= parity ^ data_out_r;
                        data_out_r <= rd_data;
                        rd_idx     <= rd_idx + ONE;
                        state      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!bus.busy) begin
                        parity <= parity ^ data_out_r;
                        if (rd_idx == len_r) begin
                            data_out_r  <= parity ^ data_out_r;
                            pkt_valid_r <= 1'b0;
                            state       <= PARITY;
                        end else begin
                            data_out_r <= rd_data;
                            rd_idx     <= rd_idx + ONE;
                        end
                    end
                end
                PARITY: begin
                    if (!bus.busy) begin
                        data_out_r <= '0;
                        tx_done_r  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    idle_r <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.pkt_valid = pkt_valid_r;
    assign bus.pay_ready = pay_ready_r;
    assign bus.tx_done   = tx_done_r;
    assign bus.tx_err    = tx_err_r;
    assign bus.idle      = idle_r;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard bench for router_pkt_tx
module tb_router_pkt_tx;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_sent   = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [7:0] e;
        check_val({tag, "_avail"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(tag, bus.data_out, e);
            n_sent++;
        end
    endtask

    // the router takes a byte on the edge following a cycle with pkt_valid=1 and busy=0
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_valid && prev_busy && bus.pkt_valid)
                check_val("hold", bus.data_out, prev_data);
            if (bus.pkt_valid && !bus.busy)
                sb_pop("byte");
            else if (!bus.pkt_valid && prev_valid && !bus.idle)
                sb_pop("parity");
        end
        prev_valid <= bus.pkt_valid;
        prev_busy  <= bus.busy;
        prev_data  <= bus.data_out;
    end

    task automatic push_pkt(input logic [1:0] a, input logic [7:0] bytes[$]);
        logic [7:0] p;
        p = {6'(bytes.size()), a};
        exp_q.push_back(p);
        foreach (bytes[i]) begin
            exp_q.push_back(bytes[i]);
            p = p ^ bytes[i];
        end
        exp_q.push_back(p);
    endtask

    task automatic issue_start(input logic [1:0] a, input logic [5:0] l);
        bus.start     = 1'b1;
        bus.dest_addr = a;
        bus.pay_len   = l;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] bytes[$], input bit toggle, input bit stray);
        int k = 0;
        int guard = 0;
        bit hs;
        while (k < bytes.size() && guard < 2000) begin
            guard++;
            bus.pay_data  = bytes[k];
            bus.pay_valid = toggle ? guard[0] : 1'b1;
            bus.busy      = 1'($urandom_range(0, 1));
            bus.start     = stray && (guard == 1);
            if (stray && guard == 1) begin
                bus.dest_addr = 2'd2;
                bus.pay_len   = 6'd1;
            end
            hs = bus.pay_valid && bus.pay_ready;
            @(posedge clock); #1;
            if (hs) k++;
        end
        bus.start     = 1'b0;
        bus.pay_valid = 1'b0;
        bus.busy      = 1'b0;
        check_val("load_complete", k, bytes.size());
        check_val("pay_ready_off", bus.pay_ready, 0);
    endtask

    task automatic drain(input int hdr_hold, input int pos_b, input int pos_hold, input int par_hold,
                         input bit rnd, input bit stray, input int abort_at);
        int acc = 0;
        int guard = 0;
        bit done_seen = 1'b0;
        while (!done_seen && guard < 3000) begin
            guard++;
            bus.start = 1'b0;
            if (bus.tx_done) begin
                done_seen = 1'b1;
                check_val("done_pkt_valid", bus.pkt_valid, 0);
                check_val("done_data_out", bus.data_out, 0);
            end else begin
                if (abort_at >= 0 && acc == abort_at) begin
                    reset    = 1'b1;
                    bus.busy = 1'b1;
                    @(posedge clock); #1;
                    reset    = 1'b0;
                    bus.busy = 1'b0;
                    return;
                end
                if (bus.pkt_valid) begin
                    if (acc == 0 && hdr_hold > 0) begin
                        bus.busy = 1'b1;
                        hdr_hold--;
                    end else if (acc == pos_b && pos_hold > 0) begin
                        bus.busy = 1'b1;
                        pos_hold--;
                    end else begin
                        bus.busy = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                    end
                    if (stray && acc == 3) begin
                        bus.start     = 1'b1;
                        bus.dest_addr = 2'd2;
                        bus.pay_len   = 6'd1;
                    end
                    if (!bus.busy) acc++;
                end else if (par_hold > 0) begin
                    bus.busy = 1'b1;
                    par_hold--;
                end else begin
                    bus.busy = 1'b0;
                end
                @(posedge clock); #1;
            end
        end
        bus.busy = 1'b0;
        check_val("tx_done_seen", done_seen, 1);
        if (done_seen) begin
            @(posedge clock); #1;
            check_val("tx_done_width", bus.tx_done, 0);
            check_val("idle_after", bus.idle, 1);
        end
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [7:0] bytes[$], input bit toggle,
                           input int hdr_hold, input int pos_b, input int pos_hold, input int par_hold,
                           input bit rnd, input bit stray);
        n_sent = 0;
        push_pkt(a, bytes);
        issue_start(a, 6'(bytes.size()));
        check_val("pay_ready_on", bus.pay_ready, 1);
        check_val("idle_low", bus.idle, 0);
        load_bytes(bytes, toggle, stray);
        drain(hdr_hold, pos_b, pos_hold, par_hold, rnd, stray, -1);
        check_val("sb_empty", exp_q.size(), 0);
        check_val("sent_count", n_sent, bytes.size() + 2);
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        issue_start(a, l);
        check_val("err_pulse", bus.tx_err, 1);
        check_val("err_idle", bus.idle, 1);
        check_val("err_pay_ready", bus.pay_ready, 0);
        check_val("err_pkt_valid", bus.pkt_valid, 0);
        @(posedge clock); #1;
        check_val("err_width", bus.tx_err, 0);
        check_val("err_pay_ready2", bus.pay_ready, 0);
        check_val("err_pkt_valid2", bus.pkt_valid, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        bus.start     = 1'b0;
        bus.dest_addr = '0;
        bus.pay_len   = '0;
        bus.pay_data  = '0;
        bus.pay_valid = 1'b0;
        bus.busy      = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_idle", bus.idle, 1);
        check_val("rst_pkt_valid", bus.pkt_valid, 0);
        check_val("rst_data_out", bus.data_out, 0);
        check_val("rst_pay_ready", bus.pay_ready, 0);
        check_val("rst_tx_done", bus.tx_done, 0);
        check_val("rst_tx_err", bus.tx_err, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        q = '{8'h11, 8'h22, 8'h33};
        run_pkt(2'd1, q, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_pkt(2'd1, q, 1'b0, 3, 2, 2, 1, 1'b0, 1'b0);

        bad_start(2'd3, 6'd5);
        bad_start(2'd1, 6'd0);

        q = {};
        for (int i = 0; i < 63; i++) q.push_back(8'($urandom));
        run_pkt(2'd2, q, 1'b1, 0, 0, 0, 0, 1'b1, 1'b0);

        q = {};
        for (int i = 0; i < 10; i++) q.push_back(8'(8'h40 + i));
        push_pkt(2'd0, q);
        issue_start(2'd0, 6'd10);
        load_bytes(q, 1'b0, 1'b0);
        drain(0, 0, 0, 0, 1'b0, 1'b0, 6);
        check_val("abort_idle", bus.idle, 1);
        check_val("abort_pkt_valid", bus.pkt_valid, 0);
        check_val("abort_data_out", bus.data_out, 0);
        check_val("abort_pay_ready", bus.pay_ready, 0);
        check_val("abort_tx_done", bus.tx_done, 0);
        exp_q.delete();
        @(posedge clock); #1;
        q = '{8'hA5};
        run_pkt(2'd2, q, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);

        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_pkt(2'd0, q, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_val("no_second_pkt", bus.pkt_valid, 0);
            check_val("stay_idle", bus.idle, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
